conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Sequences one fully-connected/conv layer pass through the WIDTH-lane float multiply + adder-tree dot-product datapath. Per start command it issues num_outputs × num_chunks memory read requests for input and weight slices, and keeps the datapath enabled while data is in flight. It tracks each slice through the fixed datapath latency and tags every partial dot-product leaving the datapath with its output index and a last-chunk flag. Sits between the layer buffer memories and the datapath; partial-sum accumulation is downstream.

Parameters:
WIDTH, 8, lanes per slice; address stride per chunk
PIPE_LAT, 27, cycles from slice presented at datapath input to its result on out_data (5 mult + 3×7 add + 1 output reg)
ADDR_W, 16, memory word address width
MAX_OUT, 4, max outstanding read requests (memory response depth)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle command pulse; sampled only in IDLE
num_outputs  in  16  output neurons this pass
num_chunks  in  8  WIDTH-slices per output
in_base  in  ADDR_W  input vector base address
wt_base  in  ADDR_W  weight matrix base address
rd_req  out  1  read request, in_addr/wt_addr valid
rd_gnt  in  1  request accepted this cycle
in_addr  out  ADDR_W  input slice address
wt_addr  out  ADDR_W  weight slice address
rd_valid  in  1  slice data on datapath inputs this cycle (in order)
dp_enable  out  1  datapath enable
res_valid  out  1  datapath out_data holds a valid partial
res_last  out  1  partial is last chunk of its output
res_index  out  16  output index of partial
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at pass end
err  out  1  sticky: rd_valid with zero outstanding

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; counters, credits, tag pipe cleared. Reset mid-pass abandons it; no done.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: start latches config, in_addr←in_base, wt_addr←wt_base → ISSUE. If num_outputs==0 or num_chunks==0 → DONE directly (no requests, done pulse 1 cycle after start).
- ISSUE: rd_req=1 while outstanding<MAX_OUT. Request retires on rd_req&rd_gnt; addresses/rd_req held stable until grant. On grant: chunk_cnt++, in_addr+=WIDTH, wt_addr+=WIDTH; at chunk wrap (chunk_cnt==num_chunks-1): chunk_cnt←0, in_addr←in_base, out_cnt++. wt_addr never rewinds (row-major weights). Final grant → WAIT.
- outstanding: +1 on grant, −1 on rd_valid; simultaneous → unchanged. Never exceeds MAX_OUT.
- Response side: own (resp_out, resp_chunk) counters advance per rd_valid. Each rd_valid pushes {1, last=(resp_chunk==num_chunks-1), resp_out} into a PIPE_LAT-deep tag shift register; bubble cycles push 0.
- res_valid/res_last/res_index = tag pipe output: res_valid exactly PIPE_LAT cycles after the corresponding rd_valid. No backpressure; consumer must accept every res_valid.
- WAIT: → DRAIN when outstanding==0 (incl. same-cycle final rd_valid).
- DRAIN: counts PIPE_LAT cycles from last rd_valid; → DONE when tag pipe empty.
- DONE: done=1 one cycle, → IDLE.
- dp_enable=1 in ISSUE/WAIT/DRAIN, 0 in IDLE/DONE (datapath adders clear when low; never drop mid-pass).
- rd_valid in IDLE/DONE or with outstanding==0: ignored, err←1 (cleared only by reset).
- start while busy ignored.

Test Plan:
- num_outputs=2, num_chunks=3, in_base=0x100, wt_base=0x400, rd_gnt=1, rd_valid 2 cycles after each grant → 6 requests; in_addr 0x100,0x108,0x110,0x100,0x108,0x110; wt_addr 0x400..0x428 step 8; res_valid 6×, res_last on 3rd/6th, res_index 0,0,0,1,1,1; done once.
- rd_valid held off: 4 grants, then rd_req low until rd_valid → outstanding never >4; rd_req reasserts the cycle after first rd_valid.
- rd_gnt low 5 cycles with rd_req high → addresses stable, no counter advance.
- num_chunks=0 → no rd_req, done 1 cycle after start, busy 1 cycle then low.
- reset low mid-ISSUE → all outputs 0 immediately; after release, new start runs cleanly from in_base.
- rd_valid in IDLE → err=1, no res_valid; err persists until reset.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - layer pass sequencer for the WIDTH-lane dot-product datapath
//
// Issues num_outputs x num_chunks slice read requests. It keeps the datapath
// enabled while slices are in flight. Each partial leaving the datapath is
// tagged with its output index and a last-chunk flag.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle command pulse, sampled only in IDLE
//   num_outputs           output neurons this pass
//   num_chunks            WIDTH-slices per output
//   in_base, wt_base      input vector / weight matrix base addresses
//   rd_req, rd_gnt        slice read request / acceptance handshake
//   in_addr, wt_addr      slice addresses, valid while rd_req
//   rd_valid              slice data on datapath inputs this cycle (in order)
//   dp_enable             datapath enable (adders clear while low)
//   res_valid             datapath out_data holds a valid partial
//   res_last, res_index   tag of the partial on out_data
//   busy, done            pass status, done is a one-cycle pulse
//   err                   sticky: rd_valid seen with nothing outstanding
module conv_layer_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PIPE_LAT = 27,
    parameter int ADDR_W   = 16,
    parameter int MAX_OUT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       num_outputs,
    input  logic [7:0]        num_chunks,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] wt_base,
    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic              rd_valid,
    output logic              dp_enable,
    output logic              res_valid,
    output logic              res_last,
    output logic [15:0]       res_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched pass configuration
    logic [15:0]       cfg_outputs;
    logic [7:0]        cfg_chunks;
    logic [ADDR_W-1:0] cfg_in_base;

    // Request-side position
    logic [7:0]        chunk_cnt;
    logic [15:0]       out_cnt;

    // Response-side position, advanced by rd_valid only
    logic [7:0]        resp_chunk;
    logic [15:0]       resp_out;

    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_nxt;

    // Tag shift register, one stage per datapath cycle. Stage 0 is loaded
    // with the tag of the slice entering the datapath. The last stage lines up
    // with out_data.
    logic [PIPE_LAT-1:0]       tag_valid;
    logic [PIPE_LAT-1:0]       tag_last;
    logic [PIPE_LAT-1:0][15:0] tag_index;

    logic grant;
    logic valid_ok;
    logic chunk_wrap;
    logic last_grant;
    logic resp_is_last;
    logic pipe_drains;
    logic err_q;

    assign grant        = rd_req & rd_gnt;
    // A response counts only while requests can be in flight. Anything else is a
    // protocol error and is kept out of the tag pipe.
    assign valid_ok     = rd_valid && (outstanding != '0) &&
                          ((state == ST_ISSUE) || (state == ST_WAIT));
    assign chunk_wrap   = (chunk_cnt == (cfg_chunks - 8'd1));
    assign last_grant   = chunk_wrap && (out_cnt == (cfg_outputs - 16'd1));
    assign resp_is_last = (resp_chunk == (cfg_chunks - 8'd1));
    // The pipe is empty after this edge when nothing sits ahead of the
    // output stage. DONE then follows the final res_valid directly.
    assign pipe_drains  = ~|tag_valid[PIPE_LAT-2:0];

    assign res_valid = tag_valid[PIPE_LAT-1];
    assign res_last  = tag_last[PIPE_LAT-1];
    assign res_index = tag_index[PIPE_LAT-1];
    assign err       = err_q;

    always_comb begin
        outstanding_nxt = outstanding;
        if (grant && !valid_ok) begin
            outstanding_nxt = outstanding + OUT_W'(1);
        end else if (!grant && valid_ok) begin
            outstanding_nxt = outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        dp_enable = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if ((num_outputs == 16'd0) || (num_chunks == 8'd0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                dp_enable = 1'b1;
                rd_req    = (outstanding < MAX_OUT_C);
                if (grant && last_grant) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dp_enable = 1'b1;
                if (outstanding_nxt == '0) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dp_enable = 1'b1;
                if (pipe_drains) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_outputs <= '0;
            cfg_chunks  <= '0;
            cfg_in_base <= '0;
            in_addr     <= '0;
            wt_addr     <= '0;
            chunk_cnt   <= '0;
            out_cnt     <= '0;
            resp_chunk  <= '0;
            resp_out    <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                cfg_outputs <= num_outputs;
                cfg_chunks  <= num_chunks;
                cfg_in_base <= in_base;
                in_addr     <= in_base;
                wt_addr     <= wt_base;
                chunk_cnt   <= '0;
                out_cnt     <= '0;
                resp_chunk  <= '0;
                resp_out    <= '0;
            end

            if (grant) begin
                // Weights are row-major, so wt_addr just keeps striding. The
                // input vector is re-read from its base for every output.
                wt_addr <= wt_addr + STRIDE;
                if (chunk_wrap) begin
                    chunk_cnt <= '0;
                    in_addr   <= cfg_in_base;
                    out_cnt   <= out_cnt + 16'd1;
                end else begin
                    chunk_cnt <= chunk_cnt + 8'd1;
                    in_addr   <= in_addr + STRIDE;
                end
            end

            if (valid_ok) begin
                if (resp_is_last) begin
                    resp_chunk <= '0;
                    resp_out   <= resp_out + 16'd1;
                end else begin
                    resp_chunk <= resp_chunk + 8'd1;
                end
            end

            outstanding <= outstanding_nxt;

            if (rd_valid && !valid_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Shifts every cycle. Bubbles enter as all-zero tags, which keeps res_valid
    // at a fixed PIPE_LAT cycles behind its rd_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_last  <= '0;
            tag_index <= '0;
        end else begin
            tag_valid <= {tag_valid[PIPE_LAT-2:0], valid_ok};
            tag_last  <= {tag_last[PIPE_LAT-2:0], valid_ok & resp_is_last};
            tag_index <= {tag_index[PIPE_LAT-2:0], (valid_ok ? resp_out : 16'd0)};
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - randomized self-checking bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

    localparam int W   = 8;
    localparam int LAT = 27;
    localparam int MO  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_outputs = '0;
    logic [7:0]  num_chunks = '0;
    logic [15:0] in_base = '0;
    logic [15:0] wt_base = '0;
    logic        rd_gnt = 1'b0;
    logic        rd_valid = 1'b0;
    logic        rd_req;
    logic [15:0] in_addr;
    logic [15:0] wt_addr;
    logic        dp_enable;
    logic        res_valid;
    logic        res_last;
    logic [15:0] res_index;
    logic        busy;
    logic        done;
    logic        err;

    conv_layer_sequencer #(.WIDTH(W), .PIPE_LAT(LAT), .ADDR_W(16), .MAX_OUT(MO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .num_outputs(num_outputs), .num_chunks(num_chunks),
        .in_base(in_base), .wt_base(wt_base),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .in_addr(in_addr), .wt_addr(wt_addr),
        .rd_valid(rd_valid), .dp_enable(dp_enable),
        .res_valid(res_valid), .res_last(res_last), .res_index(res_index),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Behavioural model of one pass
    bit          active = 1'b0;
    int          s_cyc = 0;
    int          done_cyc = 0;
    int          no = 0;
    int          nc = 0;
    int          total = 0;
    int          g_cnt = 0;
    int          v_cnt = 0;
    int          outs = 0;
    logic [15:0] ib = '0;
    logic [15:0] wb = '0;
    int          gnt_pct = 100;
    int          dly_fixed = 0;
    bit          hold_mode = 1'b0;
    int          hold_rel = -1;
    bit          stall_mode = 1'b0;
    int          stall_until = -1;
    bit          poke_start = 1'b0;
    bit          exp_err = 1'b0;
    int          ready_q[$];
    logic [16:0] exp_res[int];

    // Observation log for the literal-pinned first pass
    bit          rec = 1'b0;
    logic [15:0] obs_in[$];
    logic [15:0] obs_wt[$];
    logic [15:0] obs_idx[$];
    logic        obs_last[$];
    int          done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_req_f();
        return active && (cyc > s_cyc) && (g_cnt < total) && (outs < MO);
    endfunction

    task automatic compare();
        bit exp_busy;
        bit exp_done;
        logic [15:0] ea;
        logic [15:0] ew;
        exp_busy = active && (cyc > s_cyc) && (cyc <= done_cyc);
        exp_done = active && (cyc == done_cyc);
        chk("rd_req", {31'd0, rd_req}, {31'd0, exp_req_f()});
        if (exp_req_f()) begin
            ea = 16'(ib + (g_cnt % nc) * W);
            ew = 16'(wb + g_cnt * W);
            chk("in_addr", {16'd0, in_addr}, {16'd0, ea});
            chk("wt_addr", {16'd0, wt_addr}, {16'd0, ew});
        end
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("dp_enable", {31'd0, dp_enable}, {31'd0, (exp_busy && !exp_done)});
        if (exp_res.exists(cyc)) begin
            chk("res_valid", {31'd0, res_valid}, 32'd1);
            chk("res_last", {31'd0, res_last}, {31'd0, exp_res[cyc][16]});
            chk("res_index", {16'd0, res_index}, {16'd0, exp_res[cyc][15:0]});
            if (rec && res_valid) begin
                obs_idx.push_back(res_index);
                obs_last.push_back(res_last);
            end
            exp_res.delete(cyc);
        end else begin
            chk("res_valid", {31'd0, res_valid}, 32'd0);
        end
        if (rec && done) done_seen++;
        chk("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic drive(input bit do_start);
        bit g;
        bit gr;
        bit allow;
        int ready;
        gr = 1'b0;
        rd_valid = 1'b0;
        start = do_start;
        if (!do_start) begin
            num_outputs = 16'($urandom);
            num_chunks  = 8'($urandom);
            in_base     = 16'($urandom);
            wt_base     = 16'($urandom);
            if (poke_start && active && (cyc == s_cyc + 4)) start = 1'b1;
        end
        if (stall_mode && (g_cnt == 2) && (stall_until < 0)) stall_until = cyc + 5;
        g = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 99) < gnt_pct);
        rd_gnt = g;
        if (g && exp_req_f()) begin
            if (rec) begin
                obs_in.push_back(in_addr);
                obs_wt.push_back(wt_addr);
            end
            g_cnt++;
            gr = 1'b1;
            ready = cyc + ((dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 6)));
            if ((ready_q.size() > 0) && (ready <= ready_q[$])) ready = ready_q[$] + 1;
            ready_q.push_back(ready);
        end
        if (hold_mode && (hold_rel < 0) && (ready_q.size() == MO)) hold_rel = cyc + 3;
        allow = !hold_mode || ((hold_rel >= 0) && (cyc >= hold_rel));
        if (allow && (ready_q.size() > 0) && (ready_q[0] <= cyc)) begin
            rd_valid = 1'b1;
            void'(ready_q.pop_front());
            exp_res[cyc + LAT] = {((v_cnt % nc) == nc - 1), 16'(v_cnt / nc)};
            v_cnt++;
            if (v_cnt == total) done_cyc = cyc + LAT + 1;
            outs = outs + (gr ? 1 : 0) - 1;
        end else begin
            outs = outs + (gr ? 1 : 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare();
        drive(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
        chk({tag, "_in_addr"}, {16'd0, in_addr}, 32'd0);
        chk({tag, "_wt_addr"}, {16'd0, wt_addr}, 32'd0);
        chk({tag, "_dp_enable"}, {31'd0, dp_enable}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_last"}, {31'd0, res_last}, 32'd0);
        chk({tag, "_res_index"}, {16'd0, res_index}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic reset_mid();
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        active = 1'b0;
        ready_q.delete();
        exp_res.delete();
        outs = 0;
        exp_err = 1'b0;
        rd_valid = 1'b0;
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic run_pass(input int o, input int c, input logic [15:0] ib_i,
                            input logic [15:0] wb_i, input int gp, input int dly,
                            input bit hold, input bit stall, input bit poke,
                            input int rst_at);
        int guard;
        no = o; nc = c; total = o * c; ib = ib_i; wb = wb_i;
        g_cnt = 0; v_cnt = 0; outs = 0; ready_q.delete();
        gnt_pct = gp; dly_fixed = dly; hold_mode = hold; hold_rel = -1;
        stall_mode = stall; stall_until = -1; poke_start = poke;
        @(negedge clk);
        cyc++;
        compare();
        num_outputs = 16'(o);
        num_chunks  = 8'(c);
        in_base     = ib_i;
        wt_base     = wb_i;
        s_cyc = cyc;
        active = 1'b1;
        done_cyc = (total == 0) ? cyc + 1 : 32'h7fff_ffff;
        drive(1'b1);
        guard = 0;
        while (cyc < done_cyc) begin
            step();
            guard++;
            if ((rst_at > 0) && (guard == rst_at)) begin
                reset_mid();
                return;
            end
            if (guard > 4000) begin
                chk("pass_timeout", 32'd0, 32'd1);
                break;
            end
        end
        active = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [15:0] lit_in[6];
        logic [15:0] lit_wt[6];
        logic [15:0] lit_idx[6];
        logic        lit_last[6];
        lit_in   = '{16'h100, 16'h108, 16'h110, 16'h100, 16'h108, 16'h110};
        lit_wt   = '{16'h400, 16'h408, 16'h410, 16'h418, 16'h420, 16'h428};
        lit_idx  = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        lit_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        step();
        step();

        // Directed pass with literal expectations
        rec = 1'b1;
        run_pass(2, 3, 16'h100, 16'h400, 100, 2, 1'b0, 1'b0, 1'b0, 0);
        rec = 1'b0;
        chk("p1_grant_count", obs_in.size(), 32'd6);
        chk("p1_result_count", obs_idx.size(), 32'd6);
        chk("p1_done_count", done_seen, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_in.size()) begin
                chk("p1_in_addr_lit", {16'd0, obs_in[i]}, {16'd0, lit_in[i]});
                chk("p1_wt_addr_lit", {16'd0, obs_wt[i]}, {16'd0, lit_wt[i]});
            end
            if (i < obs_idx.size()) begin
                chk("p1_index_lit", {16'd0, obs_idx[i]}, {16'd0, lit_idx[i]});
                chk("p1_last_lit", {31'd0, obs_last[i]}, {31'd0, lit_last[i]});
            end
        end

        // Stray rd_valid in IDLE sets sticky err and yields no result
        @(negedge clk);
        cyc++;
        compare();
        start = 1'b0;
        rd_gnt = 1'b0;
        rd_valid = 1'b1;
        exp_err = 1'b1;
        repeat (3) step();

        run_pass(2, 4, 16'h040, 16'h900, 100, 0, 1'b1, 1'b0, 1'b0, 0);
        run_pass(3, 2, 16'h300, 16'h1000, 100, 0, 1'b0, 1'b1, 1'b1, 0);
        run_pass(5, 0, 16'h500, 16'h600, 100, 0, 1'b0, 1'b0, 1'b0, 0);
        run_pass(0, 3, 16'h500, 16'h600, 100, 0, 1'b0, 1'b0, 1'b0, 0);
        run_pass(3, 3, 16'h700, 16'h2000, 100, 0, 1'b0, 1'b0, 1'b0, 6);
        run_pass(2, 3, 16'h200, 16'h800, 100, 0, 1'b0, 1'b0, 1'b0, 0);

        for (int p = 0; p < 8; p++) begin
            run_pass(int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
                     16'($urandom), 16'($urandom), int'($urandom_range(40, 100)),
                     0, 1'b0, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
